// File: rtl/vga_stream_ctrl.sv
// Programmable VGA raster engine: pixel-clock divider, h/v counters, run/stop handshake
// and registered colour/sync/blank outputs lagging the counters by one pixel.
module vga_stream_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned COLOR_W  = 10,
    parameter int unsigned CLK_DIV  = 2,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned FRAME_W  = 8,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               run,
    output logic               done,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               pix_req,
    output logic [HW-1:0]      pix_x,
    output logic [VW-1:0]      pix_y,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic               vga_sync_n,
    output logic               vga_clk
);

    localparam int unsigned   DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam int unsigned   HS_START = H_ACTIVE + H_FP;
    localparam int unsigned   HS_END   = HS_START + H_SYNC;
    localparam int unsigned   VS_START = V_ACTIVE + V_FP;
    localparam int unsigned   VS_END   = VS_START + V_SYNC;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_STOP   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [DW-1:0]      div_q, div_d;
    logic [HW-1:0]      h_q, h_d;
    logic [VW-1:0]      v_q, v_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic               hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic               vclk_q, vclk_d, done_q, done_d, fs_q, fs_d;

    logic streaming_c, pix_en_c, h_last_c, v_last_c, frame_end_c;
    logic req_c, hs_win_c, vs_win_c;

    // Raster decode from the current counter values
    assign streaming_c = (state_q != S_IDLE);
    assign pix_en_c    = streaming_c && (div_q == DIV_LAST);
    assign h_last_c    = (32'(h_q) == H_TOTAL - 1);
    assign v_last_c    = (32'(v_q) == V_TOTAL - 1);
    assign frame_end_c = pix_en_c && h_last_c && v_last_c;
    assign req_c       = streaming_c && (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    assign hs_win_c    = (32'(h_q) >= HS_START) && (32'(h_q) < HS_END);
    assign vs_win_c    = (32'(v_q) >= VS_START) && (32'(v_q) < VS_END);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        done_d  = 1'b0;
        fs_d    = 1'b0;
        vclk_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (run) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (!run) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // A returning run keeps streaming without a gap; otherwise stop at frame end
                if (run) begin
                    state_d = S_ACTIVE;
                end else if (frame_end_c) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (streaming_c) begin
            div_d = pix_en_c ? '0 : div_q + DW'(1);
        end

        // Pixel step: advance counters and register this pixel's outputs
        if (pix_en_c) begin
            fs_d = (h_q == '0) && (v_q == '0);
            if (h_last_c) begin
                h_d = '0;
                v_d = v_last_c ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
            if (frame_end_c) begin
                frame_d = frame_q + FRAME_W'(1);
            end
            r_d     = req_c ? pix_r : '0;
            g_d     = req_c ? pix_g : '0;
            b_d     = req_c ? pix_b : '0;
            hs_d    = hs_win_c ? HS_POL : ~HS_POL;
            vs_d    = vs_win_c ? VS_POL : ~VS_POL;
            blank_d = req_c;
        end

        // Stopping returns the datapath to its idle state
        if (done_d) begin
            div_d   = '0;
            h_d     = '0;
            v_d     = '0;
            r_d     = '0;
            g_d     = '0;
            b_d     = '0;
            hs_d    = ~HS_POL;
            vs_d    = ~VS_POL;
            blank_d = 1'b0;
        end

        vclk_d = (div_d >= DIV_HALF);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            blank_q <= 1'b0;
            vclk_q  <= 1'b0;
            done_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            vclk_q  <= vclk_d;
            done_q  <= done_d;
            fs_q    <= fs_d;
        end
    end

    assign done        = done_q;
    assign frame_start = fs_q;
    assign frame_cnt   = frame_q;
    assign pix_req     = req_c;
    assign pix_x       = h_q;
    assign pix_y       = v_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_q;
    assign vga_sync_n  = 1'b1;
    assign vga_clk     = vclk_q;

endmodule

// File: tb/tb_vga_stream_ctrl.sv
// Scoreboard bench for vga_stream_ctrl on a 16x8 raster (8x4 visible), CLK_DIV=2, FRAME_W=4.
module tb_vga_stream_ctrl;

    localparam int unsigned CW = 10;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n;
    logic          run;
    logic          done, frame_start, pix_req;
    logic [3:0]    frame_cnt;
    logic [3:0]    pix_x;
    logic [2:0]    pix_y;
    logic [CW-1:0] pix_r, pix_g, pix_b;
    logic [CW-1:0] vga_r, vga_g, vga_b;
    logic          vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;

    vga_stream_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .COLOR_W(CW), .CLK_DIV(2), .HS_POL(1'b0), .VS_POL(1'b0), .FRAME_W(4)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .run(run),
        .done(done), .frame_start(frame_start), .frame_cnt(frame_cnt),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n), .vga_clk(vga_clk)
    );

    always #5 clk_clk = ~clk_clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {colours, hs, vs, blank_n, done, frame_start, vga_clk, sync_n, pix_req, frame_cnt, pix_x, pix_y}
    function automatic logic [63:0] obs_idle();
        return 64'({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, done, frame_start,
                    vga_clk, vga_sync_n, pix_req, frame_cnt, pix_x, pix_y});
    endfunction

    localparam logic [63:0] IDLE_EXP = {15'd0, 30'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                        1'b1, 1'b0, 4'd0, 4'd0, 3'd0};

    typedef struct packed {
        logic [3:0]    x;
        logic [2:0]    y;
        logic [CW-1:0] r, g, b;
        logic          hs, vs, blank_n;
    } pix_t;

    pix_t       exp_q[$];
    logic       prev_valid = 1'b0;
    logic [3:0] prev_x = 4'd0;
    logic [2:0] prev_y = 3'd0;
    logic       fs_valid = 1'b0;
    logic       done_prev = 1'b0;
    int         last_fs_cyc = 0;
    int         fs_count = 0;
    int         done_count = 0;

    // Upstream source: colour follows the requested coordinate
    initial begin
        pix_r = '0;
        pix_g = '0;
        pix_b = CW'(10'h3FF);
        forever begin
            @(negedge clk_clk);
            pix_r = CW'(pix_x);
            pix_g = CW'(pix_y);
        end
    end

    // Scoreboard: push on the cycle before a pixel step, pop one clk later
    always @(negedge clk_clk) begin : monitor
        pix_t       e;
        logic       fs_exp, req_exp;
        logic [3:0] ex;
        logic [2:0] ey;
        if (!reset_reset_n) begin
            exp_q.delete();
            prev_valid = 1'b0;
            fs_valid   = 1'b0;
            done_prev  = 1'b0;
        end else begin
            fs_exp = 1'b0;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pixel_out", 64'({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}),
                      64'({e.r, e.g, e.b, e.hs, e.vs, e.blank_n}));
                fs_exp = (e.x == 4'd0) && (e.y == 3'd0);
            end
            check("frame_start", 64'(frame_start), 64'(fs_exp));
            if (frame_start) begin
                if (fs_valid) check("fs_spacing", 64'(cyc - last_fs_cyc), 64'd256);
                fs_valid    = 1'b1;
                last_fs_cyc = cyc;
                fs_count++;
            end
            if (done) begin
                check("done_width", 64'(done_prev), 64'd0);
                done_count++;
                prev_valid = 1'b0;
                fs_valid   = 1'b0;
            end
            done_prev = done;
            if (vga_clk) begin
                ex = prev_valid ? prev_x + 4'd1 : 4'd0;
                ey = !prev_valid ? 3'd0 : (prev_x == 4'd15) ? prev_y + 3'd1 : prev_y;
                check("pix_xy", 64'({pix_x, pix_y}), 64'({ex, ey}));
                req_exp = (ex < 4'd8) && (ey < 3'd4);
                check("pix_req", 64'(pix_req), 64'(req_exp));
                e.x       = ex;
                e.y       = ey;
                e.r       = req_exp ? CW'(ex) : '0;
                e.g       = req_exp ? CW'(ey) : '0;
                e.b       = req_exp ? CW'(10'h3FF) : '0;
                e.hs      = !((ex >= 4'd10) && (ex <= 4'd12));
                e.vs      = !((ey >= 3'd5) && (ey <= 3'd6));
                e.blank_n = req_exp;
                exp_q.push_back(e);
                prev_x     = ex;
                prev_y     = ey;
                prev_valid = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge clk_clk);
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        int lat, n, k;
        int hs_lo, vs_lo, blank_hi, req_hi, fs_hi;
        logic [63:0] stop_exp;

        // Reset and idle with run low
        reset_reset_n = 1'b0;
        run           = 1'b0;
        repeat (4) tick();
        check("reset_hold", obs_idle(), IDLE_EXP);
        reset_reset_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            check("idle", obs_idle(), IDLE_EXP);
        end

        // Start streaming; first frame_start CLK_DIV clks after run is taken
        run = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!frame_start && lat < 20);
        check("start_latency", 64'(lat), 64'd3);

        // One full frame of timing statistics
        hs_lo = 0; vs_lo = 0; blank_hi = 0; req_hi = 0; fs_hi = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (!vga_hs)     hs_lo++;
            if (!vga_vs)     vs_lo++;
            if (vga_blank_n) blank_hi++;
            if (pix_req)     req_hi++;
            if (frame_start) fs_hi++;
        end
        check("hs_low_clks", 64'(hs_lo), 64'd48);
        check("vs_low_clks", 64'(vs_lo), 64'd64);
        check("blank_hi_clks", 64'(blank_hi), 64'd64);
        check("req_hi_clks", 64'(req_hi), 64'd64);
        check("fs_per_frame", 64'(fs_hi), 64'd1);
        check("frame_cnt_1", 64'(frame_cnt), 64'd1);

        // Drop run mid-frame; the frame must complete before done
        n = 0;
        while (pix_y != 3'd2 && n < 600) begin
            tick();
            n++;
        end
        check("reach_v2", 64'(pix_y), 64'd2);
        run = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 600);
        check("done_seen", 64'(done), 64'd1);
        check("done_latency", 64'(cyc - last_fs_cyc), 64'd254);
        check("frame_cnt_stop", 64'(frame_cnt), 64'd2);
        stop_exp = IDLE_EXP | (64'd2 << 7);
        for (int i = 0; i < 300; i++) begin
            tick();
            check("stopped", obs_idle(), stop_exp);
        end
        check("done_count_1", 64'(done_count), 64'd1);

        // Fresh start, 17 frames: frame_cnt wraps 15 -> 0
        reset_reset_n = 1'b0;
        tick();
        tick();
        check("reset_clear", obs_idle(), IDLE_EXP);
        run           = 1'b1;
        reset_reset_n = 1'b1;
        k = 0;
        n = 0;
        while (k < 17 && n < 17 * 256 + 64) begin
            tick();
            n++;
            if (frame_start) begin
                k++;
                check("frame_cnt_wrap", 64'(frame_cnt), 64'((k - 1) % 16));
            end
        end
        check("fs_pulses", 64'(k), 64'd17);

        // Asynchronous reset mid-frame
        n = 0;
        while (!(pix_x == 4'd5 && pix_y == 3'd1) && n < 300) begin
            tick();
            n++;
        end
        check("reach_h5v1", 64'({pix_x, pix_y}), 64'({4'd5, 3'd1}));
        reset_reset_n = 1'b0;
        #1;
        check("async_reset", obs_idle(), IDLE_EXP);
        tick();
        tick();
        check("no_done_on_reset", 64'(done_count), 64'd1);
        reset_reset_n = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!frame_start && lat < 20);
        check("restart_latency", 64'(lat), 64'd3);

        // Stop cleanly after the first frame following reset
        run = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 600);
        check("done_seen_2", 64'(done), 64'd1);
        check("frame_cnt_after_reset", 64'(frame_cnt), 64'd1);
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
